// File: rtl/stoch_maxpool_seq.sv
// Frame sequencer for the stochastic signed maxpool datapath: flush, warm-up,
// fixed-length evaluation window, and per-output signed integration of y_p - y_m.
module stoch_maxpool_seq #(
  parameter int unsigned NUM_OUT      = 4,
  parameter int unsigned STREAM_LEN   = 256,
  parameter int unsigned WARMUP       = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  localparam int unsigned CNT_W       = $clog2(STREAM_LEN + 1) + 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_OUT-1:0]       y_p,
  input  logic [NUM_OUT-1:0]       y_m,
  output logic                     dp_nRST,
  output logic                     src_en,
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [NUM_OUT*CNT_W-1:0] result
);

  localparam int unsigned MAX_A = (FLUSH_CYCLES > WARMUP) ? FLUSH_CYCLES : WARMUP;
  localparam int unsigned MAX_C = (MAX_A > STREAM_LEN) ? MAX_A : STREAM_LEN;
  localparam int unsigned CTR_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic               clr;
  logic [CNT_W-1:0]   acc   [NUM_OUT];
  logic [CNT_W-1:0]   acc_d [NUM_OUT];

  // Next state: counter holds remaining cycles minus one in the current phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FLUSH;
            cnt_d   = CTR_W'(FLUSH_CYCLES - 1);
            clr     = 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            if (WARMUP == 0) begin
              state_d = S_RUN;
              cnt_d   = CTR_W'(STREAM_LEN - 1);
            end else begin
              state_d = S_WARMUP;
              cnt_d   = CTR_W'(WARMUP - 1);
            end
          end else begin
            cnt_d = cnt_q - CTR_W'(1);
          end
        end
        S_WARMUP: begin
          if (cnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = CTR_W'(STREAM_LEN - 1);
          end else begin
            cnt_d = cnt_q - CTR_W'(1);
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CTR_W'(1);
          end
        end
        S_DONE: begin
          if (result_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Accumulator update: both bits high (or both low) contributes nothing
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      acc_d[i] = acc[i];
      if (clr) begin
        acc_d[i] = '0;
      end else if (state_q == S_RUN) begin
        if (y_p[i] && !y_m[i])      acc_d[i] = acc[i] + CNT_W'(1);
        else if (!y_p[i] && y_m[i]) acc_d[i] = acc[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dp_nRST      <= 1'b1;
      src_en       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) acc[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dp_nRST      <= (state_d != S_FLUSH);
      src_en       <= (state_d == S_WARMUP) || (state_d == S_RUN);
      busy         <= (state_d != S_IDLE);
      result_valid <= (state_d == S_DONE);
      for (int i = 0; i < NUM_OUT; i++) acc[i] <= acc_d[i];
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_res
    assign result[g*CNT_W +: CNT_W] = acc[g];
  end

endmodule

// File: tb/tb_stoch_maxpool_seq.sv
// Bench for stoch_maxpool_seq: two instances (L=16 and L=256) checked every cycle
// against a frame-phase model, plus directed literal expectations.
module tb_stoch_maxpool_seq;
  localparam int F = 2;
  localparam int W = 4;

  logic        CLK  = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  start = '0, abort = '0, ready = '0;
  logic [3:0]  y_p = '0, y_m = '0;
  logic [1:0]  dpn, sen, bsy, vld;
  logic [23:0] res0;
  logic [39:0] res1;

  int checks = 0;
  int failures = 0;

  // Model: ph = 0 idle, else cycles since start (1..F flush, then warm-up, run, done)
  int ph [2];
  int macc [2][4];

  int          yk = 0;
  logic [3:0]  cp = '0, cm = '0;
  bit          yrnd = 1'b1;

  always #5 CLK = ~CLK;

  stoch_maxpool_seq #(.NUM_OUT(4), .STREAM_LEN(16), .WARMUP(W), .FLUSH_CYCLES(F)) dut0 (
    .CLK(CLK), .nRST(nRST), .start(start[0]), .abort(abort[0]), .y_p(y_p), .y_m(y_m),
    .dp_nRST(dpn[0]), .src_en(sen[0]), .busy(bsy[0]), .result_valid(vld[0]),
    .result_ready(ready[0]), .result(res0));

  stoch_maxpool_seq #(.NUM_OUT(4), .STREAM_LEN(256), .WARMUP(W), .FLUSH_CYCLES(F)) dut1 (
    .CLK(CLK), .nRST(nRST), .start(start[1]), .abort(abort[1]), .y_p(y_p), .y_m(y_m),
    .dp_nRST(dpn[1]), .src_en(sen[1]), .busy(bsy[1]), .result_valid(vld[1]),
    .result_ready(ready[1]), .result(res1));

  function automatic int lk(int k);
    return (k == 0) ? 16 : 256;
  endfunction

  function automatic int cw(int k);
    return (k == 0) ? 6 : 10;
  endfunction

  function automatic logic [39:0] mres(int k);
    logic [39:0] v;
    logic [39:0] m;
    v = '0;
    m = (40'd1 << cw(k)) - 40'd1;
    for (int i = 0; i < 4; i++) v |= (40'(macc[k][i]) & m) << (i * cw(k));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame model advanced on the same edges the DUT samples
  always @(posedge CLK or negedge nRST) begin
    for (int k = 0; k < 2; k++) begin
      if (!nRST) begin
        ph[k] = 0;
        for (int i = 0; i < 4; i++) macc[k][i] = 0;
      end else if (abort[k]) begin
        ph[k] = 0;
        for (int i = 0; i < 4; i++) macc[k][i] = 0;
      end else if (ph[k] == 0) begin
        if (start[k]) begin
          ph[k] = 1;
          for (int i = 0; i < 4; i++) macc[k][i] = 0;
        end
      end else if (ph[k] == F + W + lk(k) + 1) begin
        if (ready[k]) ph[k] = 0;
      end else begin
        if (ph[k] > F + W)
          for (int i = 0; i < 4; i++) macc[k][i] += int'(y_p[i]) - int'(y_m[i]);
        ph[k]++;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge CLK) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = ph[k];
      chk($sformatf("m%0d dp_nRST", k), 40'(dpn[k]), 40'(!(p >= 1 && p <= F)));
      chk($sformatf("m%0d src_en", k), 40'(sen[k]), 40'(p > F && p <= F + W + lk(k)));
      chk($sformatf("m%0d busy", k), 40'(bsy[k]), 40'(p != 0));
      chk($sformatf("m%0d result_valid", k), 40'(vld[k]), 40'(p == F + W + lk(k) + 1));
      chk($sformatf("m%0d result", k), (k == 0) ? 40'(res0) : res1, mres(k));
    end
  end

  // Source bits: fixed pattern during the target's run window, random elsewhere
  always @(negedge CLK) begin
    if (yrnd || !(ph[yk] > F + W && ph[yk] <= F + W + lk(yk))) begin
      y_p = 4'($urandom);
      y_m = 4'($urandom);
    end else begin
      y_p = cp;
      y_m = cm;
    end
  end

  task automatic run_frame(input int k, input string tag);
    int cyc, nlow, nsrc;
    nlow = 0;
    nsrc = 0;
    @(negedge CLK);
    start[k] = 1'b1;
    @(posedge CLK);
    #1;
    start[k] = 1'b0;
    cyc = 1;
    while (!vld[k] && cyc < 400) begin
      if (!dpn[k]) nlow++;
      if (sen[k]) nsrc++;
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 40'(cyc), 40'(F + W + lk(k) + 1));
    chk({tag, " flush_len"}, 40'(nlow), 40'(F));
    chk({tag, " src_en_len"}, 40'(nsrc), 40'(W + lk(k)));
  endtask

  task automatic wait_ph(input int k, input int p, input string tag);
    int n;
    n = 0;
    while (ph[k] != p && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " reach"}, 40'(ph[k]), 40'(p));
  endtask

  task automatic release_result(input int k);
    @(negedge CLK);
    ready[k] = 1'b1;
    @(negedge CLK);
    ready[k] = 1'b0;
  endtask

  initial begin
    logic [23:0] held;
    repeat (3) @(negedge CLK);
    chk("rst dp_nRST", 40'(dpn[0]), 40'd1);
    chk("rst src_en", 40'(sen[0]), 40'd0);
    chk("rst busy", 40'(bsy[0]), 40'd0);
    chk("rst valid", 40'(vld[0]), 40'd0);
    chk("rst result", 40'(res0), 40'd0);
    nRST = 1'b1;

    // All-positive streams: every count reaches +16
    yk = 0; cp = 4'hF; cm = 4'h0; yrnd = 1'b0;
    run_frame(0, "t1");
    chk("t1 result", 40'(res0), 40'({6'd16, 6'd16, 6'd16, 6'd16}));

    // Stall in DONE with stray starts; result must hold
    held = res0;
    repeat (50) begin
      @(negedge CLK);
      start[0] = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    start[0] = 1'b0;
    chk("t4 held result", 40'(res0), 40'(held));
    chk("t4 held valid", 40'(vld[0]), 40'd1);
    chk("t4 held busy", 40'(bsy[0]), 40'd1);
    ready[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge CLK);
    ready[0] = 1'b0;
    start[0] = 1'b0;
    chk("t4 idle valid", 40'(vld[0]), 40'd0);
    chk("t4 idle busy", 40'(bsy[0]), 40'd0);
    @(negedge CLK);
    chk("t4 start ignored", 40'(bsy[0]), 40'd0);
    chk("t4 idle retains", 40'(res0), 40'(held));

    // Mixed polarity; warm-up bits randomised by the source driver
    cp = 4'b0101; cm = 4'b0011;
    run_frame(0, "t2");
    chk("t2 result", 40'(res0), 40'({6'd0, 6'd16, 6'h30, 6'd0}));
    release_result(0);

    // Full-scale on the L=256 instance
    yk = 1; cp = 4'b0010; cm = 4'b0001;
    run_frame(1, "t3");
    chk("t3 result", res1, {10'h000, 10'h000, 10'h100, 10'h300});
    release_result(1);

    // Abort at RUN cycle 7 with start high, then a fresh full frame
    yk = 0; cp = 4'hF; cm = 4'h0;
    @(negedge CLK);
    start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    wait_ph(0, F + W + 7, "t5");
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge CLK);
    #1;
    chk("t5 abort busy", 40'(bsy[0]), 40'd0);
    chk("t5 abort src_en", 40'(sen[0]), 40'd0);
    chk("t5 abort result", 40'(res0), 40'd0);
    @(negedge CLK);
    abort[0] = 1'b0;
    start[0] = 1'b0;
    run_frame(0, "t5b");
    chk("t5b result", 40'(res0), 40'({6'd16, 6'd16, 6'd16, 6'd16}));
    release_result(0);

    // Asynchronous reset during warm-up
    @(negedge CLK);
    start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    wait_ph(0, F + 2, "t6");
    chk("t6 pre src_en", 40'(sen[0]), 40'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6 rst dp_nRST", 40'(dpn[0]), 40'd1);
    chk("t6 rst src_en", 40'(sen[0]), 40'd0);
    chk("t6 rst busy", 40'(bsy[0]), 40'd0);
    chk("t6 rst valid", 40'(vld[0]), 40'd0);
    chk("t6 rst result", 40'(res0), 40'd0);
    @(negedge CLK);
    nRST = 1'b1;
    run_frame(0, "t6b");
    chk("t6b result", 40'(res0), 40'({6'd16, 6'd16, 6'd16, 6'd16}));
    release_result(0);

    // Random control and data on both instances
    yrnd = 1'b1;
    repeat (1500) begin
      @(negedge CLK);
      start = 2'($urandom);
      ready = 2'($urandom_range(0, 3) == 0 ? 3 : 0);
      abort[0] = ($urandom_range(0, 127) == 0);
      abort[1] = ($urandom_range(0, 511) == 0);
    end
    @(negedge CLK);
    start = '0; ready = '0; abort = '0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stoch_maxpool_seq.md
# stoch_maxpool_seq

Frame sequencer and result accumulator for the stochastic signed maxpool datapath. Per frame it flushes the pooling datapath, runs the upstream bitstream source through a warm-up interval and a fixed-length evaluation window, and integrates each output pair (y_p − y_m) into a signed count. It sits between the layer controller (start/result handshake) and one pooling instance (flattened y_p/y_m outputs, datapath reset, source enable).

## Interface
- NUM_OUT, 4: number of output stream pairs observed (flattened OUT_HEIGHT·OUT_WIDTH·CHANNELS)
- STREAM_LEN, 256: evaluation window length in cycles, ≥1
- WARMUP, 4: cycles the datapath runs before counting starts, ≥0
- FLUSH_CYCLES, 2: cycles the datapath reset is held, ≥1
- CNT_W, $clog2(STREAM_LEN+1)+1 (derived localparam): result width per output

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  synchronous cancel; any state
- y_p  in  NUM_OUT  positive stream bits from pooling datapath
- y_m  in  NUM_OUT  negative stream bits from pooling datapath
- dp_nRST  out  1  active-low reset to pooling datapath
- src_en  out  1  enable for upstream bitstream source
- busy  out  1  high whenever state ≠ IDLE
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result  out  NUM_OUT×CNT_W  packed two's-complement counts, element i at [i]

## Operation
- States: IDLE, FLUSH, WARMUP, RUN, DONE; one cycle counter of width to hold max(FLUSH_CYCLES, WARMUP, STREAM_LEN).
- IDLE: start=1 → FLUSH, counter loaded, all accumulators cleared.
- FLUSH: exactly FLUSH_CYCLES cycles → WARMUP (directly RUN if WARMUP=0).
- WARMUP: exactly WARMUP cycles → RUN.
- RUN: exactly STREAM_LEN cycles → DONE. Each RUN cycle, per output i: acc[i] += y_p[i] − y_m[i] (i.e. +1, −1 or 0; both high = 0). No saturation needed; range [−STREAM_LEN, +STREAM_LEN] fits CNT_W.
- DONE: result_valid=1, result stable. result_ready=1 → IDLE.
- Output decode (from state register only, no input paths): dp_nRST=0 only in FLUSH; src_en=1 in WARMUP and RUN; result_valid=1 only in DONE; busy=1 in all non-IDLE states.
- result = accumulators, continuously driven; retains last frame's values in IDLE until next start.
- abort=1: next state IDLE, accumulators cleared, counter cleared. Priority abort > result_ready > start.
- start while not IDLE: ignored, no queueing. start and result_ready both high in DONE: returns to IDLE, start ignored.
- Async reset: state IDLE, counter 0, accumulators 0; outputs dp_nRST=1, src_en=0, busy=0, result_valid=0, result=0.

## Timing
- Start sampled at edge 0 → FLUSH cycles 1..F, WARMUP F+1..F+W, RUN F+W+1..F+W+L, result_valid rises at cycle F+W+L+1 (F=FLUSH_CYCLES, W=WARMUP, L=STREAM_LEN).
- y_p/y_m sampled on the same edges that end each RUN cycle; exactly L samples per frame, none during WARMUP or first DONE cycle.
- result_valid held indefinitely until result_ready; handshake completes on the edge where both high; result_valid low next cycle.
- Back-to-back: minimum one IDLE cycle between frames.
- Reset mid-frame: immediate return to reset values, no partial result.

## Test plan
- F=2,W=4,L=16,NUM_OUT=4; start pulse, y_p=4'b1111,y_m=0 → dp_nRST low exactly 2 cycles, src_en high 20 cycles, result_valid at cycle 23, every result = +16.
- y_p=4'b0101,y_m=4'b0011 constant → results [i]: i0=0, i1=−16, i2=+16, i3=0; stimulus toggled during WARMUP only does not change counts.
- L=256 (CNT_W=10), y_m=1 all RUN cycles on output 0 → result[0]=10'h300 (−256); full-scale +256 on output 1 = 10'h100.
- Hold result_ready=0 for 50 cycles in DONE, random start pulses → result_valid and result stable, busy=1, no restart; ready=1 → IDLE next cycle.
- abort asserted at RUN cycle 7 with start also high → IDLE next cycle, result=0, src_en=0; next start produces a full-length fresh frame.
- nRST low during WARMUP → all outputs at reset values asynchronously; after release, start yields normal 23-cycle latency.
